// File: rtl/otp_array_ctrl.sv
// OTP antifuse array controller: start/busy/done handshake, row-sequential programming with
// bounded retry, multi-row read and program-then-verify with sticky error reporting.
module otp_array_ctrl #(
  parameter int unsigned A            = 4,
  parameter int unsigned B            = 4,
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned ADDR_WIDTH   = (B > 1) ? $clog2(B) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] column,
  input  logic [A-1:0]          data_in,
  input  logic                  writing_successful,
  input  logic [A-1:0]          output_read_circuit,
  output logic [2*B-1:0]        PL,
  output logic [B-1:0]          BL,
  output logic [A-1:0]          WLN,
  output logic [A-1:0]          WLP,
  output logic                  PRG,
  output logic                  read_active,
  output logic [A-1:0]          data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned RowW     = (A > 1) ? $clog2(A) : 1;
  localparam int unsigned RetryW   = $clog2(MAX_RETRY + 1);
  localparam int unsigned CntMax   = (PULSE_CYCLES > READ_CYCLES) ? PULSE_CYCLES : READ_CYCLES;
  localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] ReadLoad  = CntW'(READ_CYCLES - 1);

  localparam logic [1:0] ModeOff    = 2'b00;
  localparam logic [1:0] ModeRead   = 2'b01;
  localparam logic [1:0] ModeVerify = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StCheck,
    StRead,
    StVerify,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] column_q, column_d;
  logic [A-1:0]          data_q, data_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [RetryW-1:0]     retry_q, retry_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [A-1:0]          data_out_q, data_out_d;
  logic                  error_q, error_d;

  logic [RowW:0]         first_hit, next_hit;

  // Lowest set row of mask at or above 'from'; MSB flags that one exists.
  function automatic logic [RowW:0] find_row(input logic [A-1:0] mask, input int from);
    logic [RowW:0] res;
    res = '0;
    for (int i = int'(A) - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = {1'b1, RowW'(i)};
    end
    return res;
  endfunction

  always_comb begin
    first_hit = find_row(data_in, 0);
    next_hit  = find_row(data_q, int'(row_q) + 1);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    column_d   = column_q;
    data_d     = data_q;
    row_d      = row_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle: begin
        if (start && (mode != ModeOff)) begin
          mode_d   = mode;
          column_d = column;
          data_d   = data_in;
          error_d  = 1'b0;
          retry_d  = '0;
          if (32'(column) >= B) begin
            error_d = 1'b1;
            state_d = StDone;
          end else if (mode == ModeRead) begin
            state_d = StSetup;
          end else if (first_hit[RowW]) begin
            row_d   = first_hit[RowW-1:0];
            state_d = StSetup;
          end else if (mode == ModeVerify) begin
            cnt_d   = ReadLoad;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end

      StSetup: begin
        if (mode_q == ModeRead) begin
          cnt_d   = ReadLoad;
          state_d = StRead;
        end else begin
          cnt_d   = PulseLoad;
          state_d = StPulse;
        end
      end

      StPulse: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d   = cnt_q - 1'b1;
      end

      StCheck: begin
        if (writing_successful) begin
          retry_d = '0;
          if (next_hit[RowW]) begin
            row_d   = next_hit[RowW-1:0];
            state_d = StSetup;
          end else if (mode_q == ModeVerify) begin
            cnt_d   = ReadLoad;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
        end else if (retry_q >= RetryW'(MAX_RETRY - 1)) begin
          retry_d = RetryW'(MAX_RETRY);
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = StSetup;
        end
      end

      StRead: begin
        if (cnt_q == '0) begin
          data_out_d = output_read_circuit;
          state_d    = (mode_q == ModeVerify) ? StVerify : StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StVerify: begin
        // Only fuses requested but found intact count; extra blown fuses are tolerated.
        error_d = |(data_q & ~data_out_q);
        state_d = StDone;
      end

      StDone:  state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      mode_q     <= ModeOff;
      column_q   <= '0;
      data_q     <= '0;
      row_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      column_q   <= column_d;
      data_q     <= data_d;
      row_q      <= row_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  // Array drives are decoded from registered state only, so reset removes them immediately.
  logic [B-1:0] col_sel;
  logic [A-1:0] row_sel;
  logic [1:0]   pl_code;

  always_comb begin
    for (int unsigned c = 0; c < B; c++) col_sel[c] = (32'(column_q) == c);
    for (int unsigned r = 0; r < A; r++) row_sel[r] = (32'(row_q) == r);
  end

  always_comb begin
    BL          = '0;
    WLP         = '0;
    PRG         = 1'b0;
    read_active = 1'b0;
    pl_code     = 2'b00;

    unique case (state_q)
      StSetup: begin
        BL = col_sel;
        if (mode_q == ModeRead) begin
          WLP     = '1;
          pl_code = 2'b01;
        end else begin
          WLP = row_sel;
        end
      end
      StPulse: begin
        BL      = col_sel;
        WLP     = row_sel;
        PRG     = 1'b1;
        pl_code = 2'b11;
      end
      StCheck: begin
        BL      = col_sel;
        WLP     = row_sel;
        pl_code = 2'b11;
      end
      StRead: begin
        BL          = col_sel;
        WLP         = '1;
        pl_code     = 2'b01;
        read_active = 1'b1;
      end
      default: ;
    endcase

    PL = '0;
    for (int unsigned c = 0; c < B; c++) begin
      PL[2*c +: 2] = col_sel[c] ? pl_code : 2'b00;
    end
  end

  assign WLN      = ~WLP;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign data_out = data_out_q;
  assign error    = error_q;

endmodule

// File: tb/tb_otp_array_ctrl.sv
// Scoreboard bench for otp_array_ctrl: stimulus pushes model predictions, a negedge monitor
// pops and compares on every done pulse and watches drive legality in between.
module tb_otp_array_ctrl;

  localparam int A  = 4;
  localparam int B  = 4;
  localparam int PC = 8;
  localparam int MR = 3;
  localparam int RC = 2;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     mode;
  logic           start;
  logic [AW-1:0]  column;
  logic [A-1:0]   data_in;
  logic           writing_successful;
  logic [A-1:0]   output_read_circuit;
  logic [2*B-1:0] PL;
  logic [B-1:0]   BL;
  logic [A-1:0]   WLN, WLP;
  logic           PRG, read_active, busy, done, error;
  logic [A-1:0]   data_out;

  // Second instance with B=3 so that an out-of-range column is representable.
  logic           start3;
  logic [5:0]     pl3;
  logic [2:0]     bl3;
  logic [A-1:0]   wln3, wlp3, dout3;
  logic           prg3, ra3, busy3, done3, err3;

  logic [A-1:0]   ok_mask, sense;
  int             cyc = 0;
  int             errors = 0;
  int             checks = 0;
  logic [A-1:0]   model_dout = '0;

  typedef struct {
    int            done_cyc;
    logic          err;
    logic [A-1:0]  dout;
    int            pulses;
    logic [1:0]    mode;
    logic [AW-1:0] col;
    logic [A-1:0]  data;
  } exp_t;

  exp_t q[$];

  // Behavioural array: a program attempt succeeds only on rows marked good in ok_mask.
  assign writing_successful  = |(WLP & ok_mask);
  assign output_read_circuit = sense;

  otp_array_ctrl #(
    .A(A), .B(B), .PULSE_CYCLES(PC), .MAX_RETRY(MR), .READ_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .column(column),
    .data_in(data_in), .writing_successful(writing_successful),
    .output_read_circuit(output_read_circuit), .PL(PL), .BL(BL), .WLN(WLN), .WLP(WLP),
    .PRG(PRG), .read_active(read_active), .data_out(data_out), .busy(busy), .done(done),
    .error(error)
  );

  otp_array_ctrl #(
    .A(A), .B(3), .PULSE_CYCLES(PC), .MAX_RETRY(MR), .READ_CYCLES(RC)
  ) dut_b3 (
    .clk(clk), .reset(reset), .mode(mode), .start(start3), .column(column),
    .data_in(data_in), .writing_successful(1'b0), .output_read_circuit(output_read_circuit),
    .PL(pl3), .BL(bl3), .WLN(wln3), .WLP(wlp3), .PRG(prg3), .read_active(ra3),
    .data_out(dout3), .busy(busy3), .done(done3), .error(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level prediction: latency, pulse count, error and read word of one operation.
  task automatic model(input logic [1:0] m, input logic [AW-1:0] c, input logic [A-1:0] d,
                       input logic [A-1:0] ok, input logic [A-1:0] s,
                       output exp_t e, output int lat);
    int   n;
    logic fail;
    e.mode = m; e.col = c; e.data = d; e.err = 1'b0; e.dout = model_dout; e.pulses = 0;
    n = 0; fail = 1'b0;
    if (int'(c) >= B) begin
      lat = 1; e.err = 1'b1;
    end else if (m == 2'b01) begin
      lat = RC + 2; e.dout = s;
    end else begin
      for (int r = 0; r < A; r++) begin
        if (d[r] && !fail) begin
          if (ok[r]) n += 1;
          else begin n += MR; fail = 1'b1; end
        end
      end
      lat = n * (PC + 2) + 1;
      e.pulses = n;
      e.err = fail;
      if (m == 2'b11 && !fail) begin
        lat += RC + 1;
        e.dout = s;
        e.err = |(d & ~s);
      end
    end
    model_dout = e.dout;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d after %0d cycles", busy, q.size(), n);
      q.delete();
    end
  endtask

  task automatic run_txn(input logic [1:0] m, input logic [AW-1:0] c, input logic [A-1:0] d,
                         input logic [A-1:0] ok, input logic [A-1:0] s, input bit spur_at_done);
    exp_t         e;
    int           lat, t_sp;
    logic [A-1:0] low;
    logic [B-1:0] bl_exp;
    logic         oor;
    wait_idle();
    ok_mask = ok; sense = s; mode = m; column = c; data_in = d; start = 1'b1;
    model(m, c, d, ok, s, e, lat);
    e.done_cyc = cyc + lat;
    q.push_back(e);
    t_sp = spur_at_done ? lat : int'($urandom_range(lat, 1));
    oor = (int'(c) >= B);
    bl_exp = B'(1) << c;
    low = d & (~d + 4'd1);
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); column = AW'($urandom); data_in = A'($urandom);
    check("busy_rise", busy, 1);
    check("error_at_accept", error, oor);
    if (!oor && m == 2'b01) begin
      check("read_setup_bl", BL, bl_exp);
      check("read_setup_pl", PL, 8'b01 << (2 * c));
      check("read_setup_wlp", WLP, 4'hF);
    end else if (!oor && m[1] && d != 0) begin
      check("prog_setup_bl", BL, bl_exp);
      check("prog_setup_wlp", WLP, low);
      check("prog_setup_prg", PRG, 0);
    end
    for (int t = 1; t < t_sp; t++) @(negedge clk);
    // A start while busy (or in the done cycle) must be ignored.
    start = 1'b1; mode = 2'($urandom_range(3, 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : monitor
    int           prg_hi, prg_rise;
    bit           prg_prev, viol;
    exp_t         e;
    logic [B-1:0] bl_exp;
    logic [2*B-1:0] pl_exp;
    prg_hi = 0; prg_rise = 0; prg_prev = 1'b0; viol = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prg_hi = 0; prg_rise = 0; prg_prev = 1'b0; viol = 1'b0;
      end else begin
        if (WLN !== ~WLP) viol = 1'b1;
        if (q.size() != 0) begin
          e = q[0];
          bl_exp = B'(1) << e.col;
          pl_exp = '0;
          if (PRG) begin
            pl_exp[2*e.col +: 2] = 2'b11;
            if (BL !== bl_exp || PL !== pl_exp || !$onehot(WLP) || (WLP & e.data) == 0)
              viol = 1'b1;
          end
          if (read_active) begin
            pl_exp[2*e.col +: 2] = 2'b01;
            if (BL !== bl_exp || PL !== pl_exp || WLP !== 4'hF) viol = 1'b1;
          end
        end
        if (PRG) begin
          prg_hi++;
          if (!prg_prev) prg_rise++;
        end
        prg_prev = PRG;
        if (done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_done: done=1 with no operation outstanding (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("error", error, e.err);
            check("data_out", data_out, e.dout);
            check("prg_pulses", prg_rise, e.pulses);
            check("prg_high_cycles", prg_hi, e.pulses * PC);
            check("drive_legal", viol, 0);
            check("drives_off_in_done", {PL, BL, WLP, PRG, read_active}, 0);
          end
          prg_hi = 0; prg_rise = 0; viol = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0]    m;
    logic [AW-1:0] c;
    logic [A-1:0]  d, ok, s;
    bit            stayed_idle;
    int            n;
    reset = 1'b0; start = 1'b0; start3 = 1'b0; mode = '0; column = '0; data_in = '0;
    ok_mask = '0; sense = '0;
    repeat (3) @(negedge clk);
    check("rst_pl", PL, 0);
    check("rst_bl", BL, 0);
    check("rst_wlp", WLP, 0);
    check("rst_wln", WLN, 4'hF);
    check("rst_prg", PRG, 0);
    check("rst_read_active", read_active, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    run_txn(2'b01, 2'd2, 4'b0000, 4'hF, 4'b1010, 1'b0);
    run_txn(2'b10, 2'd1, 4'b0101, 4'hF, 4'b0000, 1'b0);
    run_txn(2'b10, 2'd0, 4'b0001, 4'h0, 4'b0000, 1'b1);
    run_txn(2'b01, 2'd3, 4'b0000, 4'hF, 4'b0110, 1'b0);
    run_txn(2'b11, 2'd0, 4'b0011, 4'hF, 4'b0001, 1'b0);
    run_txn(2'b11, 2'd0, 4'b0011, 4'hF, 4'b0111, 1'b1);
    run_txn(2'b10, 2'd2, 4'b0000, 4'hF, 4'b0000, 1'b0);
    run_txn(2'b11, 2'd1, 4'b0000, 4'hF, 4'b1001, 1'b0);
    run_txn(2'b11, 2'd3, 4'b1010, 4'b0010, 4'b1111, 1'b0);

    // mode 00 start must not launch anything.
    wait_idle();
    mode = 2'b00; column = 2'd1; data_in = 4'hF; start = 1'b1;
    stayed_idle = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) stayed_idle = 1'b0;
    end
    check("mode00_ignored", stayed_idle, 1);

    repeat (40) begin
      m  = 2'($urandom_range(3, 1));
      c  = AW'($urandom);
      d  = A'($urandom);
      ok = ($urandom_range(9, 0) < 7) ? 4'hF : A'($urandom);
      s  = (m == 2'b11 && $urandom_range(1, 0) == 1) ? (d | A'($urandom)) : A'($urandom);
      run_txn(m, c, d, ok, s, $urandom_range(3, 0) == 0);
    end

    wait_idle();
    mode = 2'b01; column = 2'd3; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("oor_done", done3, 1);
    check("oor_error", err3, 1);
    check("oor_busy", busy3, 1);
    check("oor_no_drive", {pl3, bl3, wlp3, prg3, ra3}, 0);
    @(negedge clk);
    check("oor_back_idle", {busy3, done3}, 0);

    // Asynchronous reset in the middle of a program pulse.
    wait_idle();
    ok_mask = 4'hF; mode = 2'b10; column = 2'd0; data_in = 4'b1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!PRG && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("prg_reached", PRG, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_prg", PRG, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_wl", {WLP, WLN}, {4'h0, 4'hF});
    check("async_rst_drive", {PL, BL, read_active}, 0);
    check("async_rst_state", {data_out, error, done}, 0);
    q.delete();
    model_dout = '0;
    @(negedge clk);
    reset = 1'b1;
    run_txn(2'b01, 2'd0, 4'b0000, 4'hF, 4'b0011, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
